// File: rtl/fir_filter_bank.sv
// fir_filter_bank: per-channel circular histories, per-filter coefficient RAMs, one MAC pass per frame.
// Optional FIR_BANK_ROUND_SAT_EN: round, saturate to DATA_W and register results one cycle later.
module fir_filter_bank #(
    parameter int NUM_CH      = 2,
    parameter int NUM_FILTERS = 4,
    parameter int MAX_TAPS    = 256,
    parameter int DATA_W      = 24,
    parameter int COEF_W      = 16,
    parameter int ACC_W       = 48,
    localparam int AW = $clog2(MAX_TAPS),
    localparam int SW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 i_audio_en,
    input  logic [AW:0]                          i_taps_per_filter,
    input  logic                                 i_coef_addr_rst,
    input  logic                                 i_coefficient_wr_en,
    input  logic [SW-1:0]                        i_coef_select,
    input  logic [COEF_W-1:0]                    i_coef_wr_data,
    output logic                                 o_wr_addr_zero,
    input  logic [NUM_CH-1:0]                    i_ch_data_en,
    input  logic [NUM_CH*DATA_W-1:0]             i_ch_data_in,
    output logic [NUM_CH*NUM_FILTERS*ACC_W-1:0]  o_data_out,
    output logic                                 o_data_valid,
    output logic                                 o_busy,
    output logic                                 o_overrun
);
    localparam int PW = DATA_W + COEF_W;
    localparam int NR = NUM_CH * NUM_FILTERS;
`ifdef FIR_BANK_ROUND_SAT_EN
    localparam int DRAIN_N = 4;
`else
    localparam int DRAIN_N = 3;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t r_state, w_next;

    logic signed [DATA_W-1:0] r_hist [NUM_CH][MAX_TAPS];
    logic signed [COEF_W-1:0] r_coef [NUM_FILTERS][MAX_TAPS];
    logic signed [DATA_W-1:0] r_xd [NUM_CH];
    logic signed [COEF_W-1:0] r_cd [NUM_FILTERS];
    logic signed [PW-1:0]     r_prod [NR];
    logic signed [ACC_W-1:0]  r_acc [NR];
    logic [AW-1:0]            r_caddr, r_wr_ptr, r_base, r_k, r_last;
    logic [NUM_CH-1:0]        r_arm;
    logic [1:0]               r_dcnt;
    logic                     r_rd_v, r_prod_v, r_valid, r_overrun;
    logic [NR*ACC_W-1:0]      r_out, w_res;
    logic                     w_done, w_start, w_fin;
    logic [AW:0]              w_n;

    assign w_done  = &(r_arm | i_ch_data_en);
    assign w_start = w_done && (r_state == IDLE);
    assign w_fin   = (r_state == DRAIN) && (w_next == IDLE);
    assign w_n = (i_taps_per_filter == '0) ? (AW+1)'(1) :
                 (i_taps_per_filter > (AW+1)'(MAX_TAPS)) ? (AW+1)'(MAX_TAPS) : i_taps_per_filter;

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && w_done)
            w_next = RUN;
        else if (r_state == RUN && r_k == r_last)
            w_next = DRAIN;
        else if (r_state == DRAIN && r_dcnt == 2'(DRAIN_N - 1))
            w_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset || !i_audio_en)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset || !i_audio_en) begin
            r_arm     <= '0;
            r_wr_ptr  <= '0;
            r_base    <= '0;
            r_k       <= '0;
            r_last    <= '0;
            r_dcnt    <= '0;
            r_rd_v    <= 1'b0;
            r_prod_v  <= 1'b0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_out     <= '0;
            for (int i = 0; i < NR; i++)
                r_acc[i] <= '0;
        end else begin
            r_arm    <= w_done ? '0 : (r_arm | i_ch_data_en);
            r_rd_v   <= (r_state == RUN);
            r_prod_v <= r_rd_v;
            r_valid  <= w_fin;
            r_k      <= (r_state == RUN) ? r_k + 1'b1 : '0;
            r_dcnt   <= (r_state == DRAIN) ? r_dcnt + 1'b1 : '0;
            if (w_done && r_state != IDLE)
                r_overrun <= 1'b1;
            // newest sample sits at base; older ones follow at base+1, base+2, ...
            if (w_start) begin
                r_base   <= r_wr_ptr;
                r_wr_ptr <= r_wr_ptr - 1'b1;
                r_last   <= AW'(w_n - 1'b1);
            end
            for (int i = 0; i < NR; i++)
                r_acc[i] <= w_start ? '0 :
                            r_prod_v ? r_acc[i] + {{(ACC_W-PW){r_prod[i][PW-1]}}, r_prod[i]} : r_acc[i];
            if (w_fin)
                r_out <= w_res;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_caddr <= '0;
        else if (i_coef_addr_rst)
            r_caddr <= '0;
        else if (i_coefficient_wr_en)
            r_caddr <= r_caddr + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset && i_coefficient_wr_en && int'(i_coef_select) < NUM_FILTERS)
            r_coef[i_coef_select][r_caddr] <= i_coef_wr_data;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!reset && i_audio_en && i_ch_data_en[c])
                r_hist[c][r_wr_ptr] <= i_ch_data_in[c*DATA_W +: DATA_W];
            r_xd[c] <= r_hist[c][r_base + r_k];
        end
        for (int f = 0; f < NUM_FILTERS; f++)
            r_cd[f] <= r_coef[f][r_k];
        for (int i = 0; i < NR; i++)
            r_prod[i] <= r_xd[i / NUM_FILTERS] * r_cd[i % NUM_FILTERS];
    end

`ifdef FIR_BANK_ROUND_SAT_EN
    localparam logic [ACC_W:0] RND = (ACC_W+1)'(1) << (COEF_W - 2);
    localparam logic signed [ACC_W:0] SMAX = (ACC_W+1)'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W:0] SMIN = ~SMAX;
    logic signed [ACC_W:0] w_rnd [NR];
    logic signed [ACC_W:0] w_sat [NR];
    logic [NR*ACC_W-1:0]   r_rs;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            w_rnd[i] = $signed({r_acc[i][ACC_W-1], r_acc[i]} + RND) >>> (COEF_W - 1);
            w_sat[i] = (w_rnd[i] > SMAX) ? SMAX : (w_rnd[i] < SMIN) ? SMIN : w_rnd[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NR; i++)
            r_rs[i*ACC_W +: ACC_W] <= ACC_W'(w_sat[i]);
    end

    assign w_res = r_rs;
`else
    always_comb begin
        w_res = '0;
        for (int i = 0; i < NR; i++)
            w_res[i*ACC_W +: ACC_W] = r_acc[i];
    end
`endif

    assign o_data_out     = r_out;
    assign o_data_valid   = r_valid;
    assign o_busy         = (r_state != IDLE) || r_valid;
    assign o_overrun      = r_overrun;
    assign o_wr_addr_zero = (r_caddr == '0);
endmodule

// File: tb/tb_fir_filter_bank.sv
// tb_fir_filter_bank: randomized frames against a sum-of-products reference model with a result scoreboard.
module tb_fir_filter_bank;
    localparam int NC = 2;
    localparam int NF = 3;
    localparam int MT = 64;
    localparam int DW = 24;
    localparam int CW = 16;
    localparam int ACCW = 48;
    localparam int AW = $clog2(MT);
    localparam int SW = 2;
    localparam int OW = NC * NF * ACCW;
`ifdef FIR_BANK_ROUND_SAT_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic clk = 0;
    logic rst = 1;
    logic audio_en = 1;
    logic [AW:0] taps = '0;
    logic addr_rst = 0, wr_en = 0;
    logic [SW-1:0] csel = '0;
    logic [CW-1:0] cdata = '0;
    logic wr_addr_zero;
    logic [NC-1:0] ch_en = '0;
    logic [NC*DW-1:0] ch_in = '0;
    logic [OW-1:0] data_out;
    logic data_valid, busy, overrun;

    fir_filter_bank #(.NUM_CH(NC), .NUM_FILTERS(NF), .MAX_TAPS(MT), .DATA_W(DW), .COEF_W(CW), .ACC_W(ACCW)) dut (
        .clk(clk), .reset(rst), .i_audio_en(audio_en), .i_taps_per_filter(taps),
        .i_coef_addr_rst(addr_rst), .i_coefficient_wr_en(wr_en), .i_coef_select(csel),
        .i_coef_wr_data(cdata), .o_wr_addr_zero(wr_addr_zero), .i_ch_data_en(ch_en),
        .i_ch_data_in(ch_in), .o_data_out(data_out), .o_data_valid(data_valid),
        .o_busy(busy), .o_overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {int cyc; logic [OW-1:0] d;} exp_t;
    exp_t q[$];
    int cyc = 0, checks = 0, errors = 0, nvalid = 0;
    logic [OW-1:0] last_out = '0;
    logic signed [DW-1:0] hist_m [NC][MT];
    logic signed [CW-1:0] coef_m [NF][MT];
    int mptr = 0, maddr = 0, next_ok = 0;
    logic [NC-1:0] arm = '0;
    logic exp_ovr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [ACCW-1:0] post(input longint s);
`ifdef FIR_BANK_ROUND_SAT_EN
        longint r;
        longint mx;
        mx = (longint'(1) <<< (DW - 1)) - 1;
        r = (s + (longint'(1) <<< (CW - 2))) >>> (CW - 1);
        if (r > mx) r = mx;
        if (r < -mx - 1) r = -mx - 1;
        return ACCW'(r);
`else
        return ACCW'(s);
`endif
    endfunction

    // y[c][f] = sum over k of coef[f][k] * x[c][n-k], the newest sample at base
    function automatic logic [OW-1:0] model(input int base, input int n);
        logic [OW-1:0] v;
        longint s;
        v = '0;
        for (int c = 0; c < NC; c++)
            for (int f = 0; f < NF; f++) begin
                s = 0;
                for (int k = 0; k < n; k++)
                    s += longint'(hist_m[c][(base + k) % MT]) * longint'(coef_m[f][k]);
                v[(c*NF + f)*ACCW +: ACCW] = post(s);
            end
        return v;
    endfunction

    always @(negedge clk) begin
        if (!rst && data_valid) begin
            checks++;
            nvalid++;
            last_out = data_out;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (data_out !== e.d || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL result cycle %0d data %h expected cycle %0d data %h", cyc, data_out, e.cyc, e.d);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        ch_en = '0;
        wr_en = 0;
        addr_rst = 0;
    endtask

    task automatic step(input logic [NC-1:0] en, input logic [NC*DW-1:0] d);
        int n;
        tick();
        ch_en = en;
        ch_in = d;
        for (int c = 0; c < NC; c++)
            if (en[c]) hist_m[c][mptr] = d[c*DW +: DW];
        arm |= en;
        if (arm == '1) begin
            arm = '0;
            if (cyc >= next_ok) begin
                n = (taps == 0) ? 1 : (int'(taps) > MT) ? MT : int'(taps);
                q.push_back('{cyc + n + LAT, model(mptr, n)});
                next_ok = cyc + n + LAT;
                mptr = (mptr + MT - 1) % MT;
            end else
                exp_ovr = 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step('0, '0);
    endtask

    function automatic logic [NC*DW-1:0] rnd();
        logic [NC*DW-1:0] v;
        for (int c = 0; c < NC; c++) v[c*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    task automatic frame(input logic [NC*DW-1:0] d, input int gap);
        step('1, d);
        idle(gap - 1);
    endtask

    task automatic wr_coef(input int sel, input logic [CW-1:0] v);
        tick();
        wr_en = 1;
        csel = SW'(sel);
        cdata = v;
        if (sel < NF) coef_m[sel][maddr] = v;
        maddr = (maddr + 1) % MT;
    endtask

    task automatic arst();
        tick();
        addr_rst = 1;
        maddr = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && q.size() > 0; i++) idle(1);
        chk("drain_timeout", 64'(q.size()), 0);
        idle(2);
    endtask

    initial begin
        int v0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", 64'(|data_out), 0);
        chk("rst_valid", 64'(data_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_overrun", 64'(overrun), 0);
        chk("rst_addr_zero", 64'(wr_addr_zero), 1);
        rst = 0;

        for (int f = 0; f < NF; f++)
            for (int k = 0; k < MT; k++) wr_coef(f, CW'($urandom));
        idle(1);
        chk("addr_wrap_zero", 64'(wr_addr_zero), 1);

        // taps 0 clamps to one tap; back-to-back frames at the earliest accepted spacing
        taps = '0;
        for (int i = 0; i < MT; i++) frame(rnd(), 1 + LAT);
        drain();

        taps = 8;
        arst();
        for (int k = 0; k < 8; k++) wr_coef(0, CW'(k + 1));
        frame({DW'($urandom), 24'h000100}, 8 + LAT);
        for (int i = 0; i < 7; i++) frame({DW'($urandom), 24'h0}, 8 + LAT);
        drain();
        chk("impulse_tail", 64'(last_out[ACCW-1:0]), 64'(post(64'h800)));

        v0 = nvalid;
        step(2'b01, rnd());
        idle(2);
        step(2'b10, rnd());
        drain();
        chk("stagger_one_valid", 64'(nvalid - v0), 1);
        v0 = nvalid;
        step(2'b11, rnd());
        drain();
        chk("same_cycle_one_valid", 64'(nvalid - v0), 1);

        arst();
        idle(1);
        chk("addr_rst_zero", 64'(wr_addr_zero), 1);
        wr_coef(NF, 16'h1234);
        idle(1);
        chk("addr_after_write", 64'(wr_addr_zero), 0);
        for (int i = 0; i < 3; i++) wr_coef(NF, CW'($urandom));
        arst();
        idle(1);
        chk("addr_rst_again", 64'(wr_addr_zero), 1);
        frame(rnd(), 8 + LAT);
        drain();

        taps = 16;
        v0 = nvalid;
        frame(rnd(), 5);
        frame(rnd(), 1);
        drain();
        chk("overrun_flag", 64'(overrun), 64'(exp_ovr));
        chk("overrun_one_valid", 64'(nvalid - v0), 1);
        frame(rnd(), 16 + LAT);
        drain();

        taps = 5;
        step('1, rnd());
        idle(1);
        chk("busy_first", 64'(busy), 1);
        idle(5 + LAT - 1);
        chk("busy_last", 64'(busy), 1);
        idle(1);
        chk("busy_done", 64'(busy), 0);
        drain();

        taps = 4;
        for (int f = 0; f < NF; f++) begin
            arst();
            for (int k = 0; k < 4; k++) wr_coef(f, 16'h7FFF);
        end
        for (int i = 0; i < 4; i++) frame({24'h800000, 24'h7FFFFF}, 4 + LAT);
        drain();
        chk("fullscale_pos", 64'(last_out[ACCW-1:0]), 64'(post(longint'(4) * 64'h7FFFFF * 64'h7FFF)));
        chk("fullscale_neg", 64'(last_out[NF*ACCW +: ACCW]), 64'(post(-longint'(4) * 64'h800000 * 64'h7FFF)));

        taps = 7'd127;
        frame(rnd(), MT + LAT);
        drain();
        taps = 7'(MT);
        for (int i = 0; i < 300; i++) frame(rnd(), MT + LAT);
        drain();

        taps = 16;
        step('1, rnd());
        idle(5);
        tick();
        audio_en = 0;
        q.delete();
        mptr = 0;
        arm = '0;
        next_ok = 0;
        exp_ovr = 0;
        tick();
        audio_en = 1;
        chk("abort_busy", 64'(busy), 0);
        chk("abort_dout", 64'(|data_out), 0);
        chk("abort_overrun", 64'(overrun), 0);
        idle(30);
        taps = 4;
        frame(rnd(), 4 + LAT);
        frame(rnd(), 4 + LAT);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog_timeout at cycle %0d", cyc);
        $fatal(1);
    end
endmodule

// File: doc/fir_filter_bank.md
# fir_filter_bank

Multi-channel, multi-filter FIR engine for the audio equalizer path, sitting between the I2S receive side and the equalizer gain/mix stage. One circular sample history per channel; one coefficient RAM per filter, shared by all channels. Each complete sample frame triggers one time-multiplexed MAC pass over a run-time tap count. It produces NUM_CH × NUM_FILTERS results with a single valid strobe.

## Interface
- NUM_CH, 2, audio channels (≥1)
- NUM_FILTERS, 4, filters/coefficient RAMs (≥1)
- MAX_TAPS, 256, history/coefficient depth, power of 2
- DATA_W, 24, signed sample width
- COEF_W, 16, signed coefficient width
- ACC_W, 48, signed accumulator/result width, ≥ DATA_W+COEF_W+log2(MAX_TAPS)
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- audio_en  in  1  low: clears frame/MAC state, pointers, flags; coefficients retained
- taps_per_filter  in  log2(MAX_TAPS)+1  tap count N; sampled at frame start
- coef_addr_rst  in  1  clears coefficient write address
- coefficient_wr_en  in  1  write strobe
- coef_select  in  max(1,clog2(NUM_FILTERS))  target filter
- coef_wr_data  in  COEF_W  coefficient value
- wr_addr_zero  out  1  coefficient write address == 0
- ch_data_en  in  NUM_CH  per-channel sample strobe
- ch_data_in  in  NUM_CH*DATA_W  packed samples, channel c at [c*DATA_W +: DATA_W]
- data_out  out  NUM_CH*NUM_FILTERS*ACC_W  result (c,f) at index c*NUM_FILTERS+f
- data_valid  out  1  one-cycle result strobe
- busy  out  1  MAC pass in progress
- overrun  out  1  sticky: frame completed while busy

## Operation
- Reset values: data_out 0, data_valid 0, busy 0, overrun 0, wr_addr_zero 1. Write pointer is 0 and arm bits are clear. RAM contents are undefined.
- audio_en low has the same effect as reset, except that the coefficient address and coefficient RAMs are untouched.
- Coefficient write: write coef_wr_data to RAM[coef_select][addr], then addr+1 mod MAX_TAPS.
  - If coef_select ≥ NUM_FILTERS, the write is dropped but the address still increments.
  - coef_addr_rst takes priority over the increment.
  - Writes are allowed while busy and take effect on subsequent reads.
- Sample capture: ch_data_en[c] writes ch_data_in[c] to history[c][wr_ptr] and sets arm[c].
  - A repeat strobe on an armed channel overwrites the sample; the latest value wins.
  - A frame completes in the cycle all arm bits are set (same-cycle strobes count). Arm bits clear on the next edge.
- Frame start, one cycle after completion, when not busy:
  - Latch N, clamped: 0→1, >MAX_TAPS→MAX_TAPS.
  - Latch base = wr_ptr.
  - wr_ptr ← wr_ptr−1 mod MAX_TAPS.
  - Clear accumulators and enter RUN.
- Frame completes while busy: the frame is dropped, overrun is set, and wr_ptr is unchanged. The next frame overwrites those samples.
- States:
  - IDLE → RUN on frame start.
  - RUN: k = 0..N−1, one tap per cycle. Read history[c][base+k mod MAX_TAPS] and coef[f][k]. Go to DRAIN after k = N−1.
  - DRAIN: 3 cycles of pipeline flush, then present the result. Return to IDLE.
- Arithmetic: signed full product DATA_W+COEF_W, sign-extended to ACC_W. The accumulator wraps (two's complement, no saturation). y[c][f] = Σ coef[f][k]·x[c][n−k].
- data_out is registered and holds until the next data_valid.

## Timing
- T = cycle in which the last channel strobe is sampled.
- Frame start at T+1. Reads at T+1..T+N. The product register is one cycle behind the read; the accumulator is one cycle behind that.
- data_valid is high for exactly cycle T+N+4. data_out updates on the same edge.
- busy is high T+1 through T+N+4 inclusive. A frame completing at T+N+4 is accepted, and its start occurs at T+N+5.
- Reset or audio_en low mid-pass aborts immediately. No data_valid is issued, and data_out returns to 0.

## Configuration
- FIR_BANK_ROUND_SAT_EN:
  - Defined: each result is arithmetic-shifted right by COEF_W−1 with round-half-up, saturated to the DATA_W signed range, and sign-extended to ACC_W. This adds one output register stage, so data_valid moves to T+N+5 and busy extends to match.
  - Undefined: raw accumulator output at T+N+4.

## Test plan
- Impulse: N=8, coef[0][k]=k+1; strobe ch0 = 0x000100 then seven zero frames → ch0 filter0 outputs 0x100·(k+1), k=0..7, each at T+12.
- Staggered enables: ch1 strobe 3 cycles after ch0 → exactly one data_valid at T+N+4, with T taken at the ch1 strobe. Same-cycle strobes behave identically.
- Overrun: N=16, second frame completes at T+5 → overrun=1, one data_valid only, wr_ptr decremented once.
- Coefficient routing: coef_select=NUM_FILTERS with 4 writes → no RAM change; wr_addr_zero low after the first write, high after coef_addr_rst.
- Clamp/wrap: taps_per_filter=0 → single-tap result x·coef[f][0]. N=MAX_TAPS over 300 frames → correct history wrap vs. reference model.
- Saturation (macro defined): x=0x7FFFFF, all coef 0x7FFF, N=4 → 0x007FFFFF. Negative full scale → sign-extended 0x800000.
